// File: rtl/ram_stream_reader.sv
// Reads consecutive 64-bit words from a dual-read-port RAM, two per fetch, and
// serializes them LSB-chunk-first onto a valid/ready stream with last/done.
module ram_stream_reader #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int CHUNK_WIDTH   = 16,
    parameter int COUNT_WIDTH   = 14
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [COUNT_WIDTH-1:0]   word_count,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] address_RD1,
    output logic [ADDRESS_WIDTH-1:0] address_RD2,
    input  logic [DATA_WIDTH-1:0]    dataIn1,
    input  logic [DATA_WIDTH-1:0]    dataIn2,
    output logic [CHUNK_WIDTH-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);
    localparam int WORD_CHUNKS     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int PAIR_CHUNKS     = 2 * WORD_CHUNKS;
    localparam int CHUNK_CNT_WIDTH = $clog2(PAIR_CHUNKS);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t                       state, state_next;
    logic [COUNT_WIDTH-1:0]       remaining;
    logic                         two_words;
    logic [CHUNK_CNT_WIDTH-1:0]   chunk_cnt;
    logic [2*DATA_WIDTH-1:0]      buffer;
    logic [ADDRESS_WIDTH-1:0]     addr1, addr2;
    logic [COUNT_WIDTH-1:0]       nwords;
    logic                         last_chunk;
    logic                         handshake;
    logic                         final_pair;

    assign nwords     = two_words ? COUNT_WIDTH'(2) : COUNT_WIDTH'(1);
    assign last_chunk = chunk_cnt == (two_words ? CHUNK_CNT_WIDTH'(PAIR_CHUNKS - 1)
                                                : CHUNK_CNT_WIDTH'(WORD_CHUNKS - 1));
    assign handshake  = (state == SEND) && out_ready;
    assign final_pair = remaining == nwords;

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = (word_count != '0) ? FETCH : DONE;
            FETCH: state_next = SEND;
            SEND:  if (handshake && last_chunk) state_next = final_pair ? DONE : FETCH;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            remaining <= '0;
            two_words <= 1'b0;
            chunk_cnt <= '0;
            buffer    <= '0;
            addr1     <= '0;
            addr2     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && word_count != '0) begin
                        remaining <= word_count;
                        addr1     <= base_addr;
                        addr2     <= base_addr + ADDRESS_WIDTH'(1);
                    end
                end
                FETCH: begin
                    // RAM reads are combinational, so the data is valid within this cycle
                    buffer    <= {dataIn2, dataIn1};
                    two_words <= remaining >= COUNT_WIDTH'(2);
                    chunk_cnt <= '0;
                end
                SEND: begin
                    if (handshake) begin
                        buffer <= buffer >> CHUNK_WIDTH;
                        if (last_chunk) begin
                            chunk_cnt <= '0;
                            remaining <= remaining - nwords;
                            if (!final_pair) begin
                                addr1 <= addr1 + ADDRESS_WIDTH'(2);
                                addr2 <= addr2 + ADDRESS_WIDTH'(2);
                            end
                        end else begin
                            chunk_cnt <= chunk_cnt + CHUNK_CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = state != IDLE;
        done        = state == DONE;
        out_valid   = state == SEND;
        out_last    = (state == SEND) && final_pair && last_chunk;
        out_data    = buffer[CHUNK_WIDTH-1:0];
        address_RD1 = addr1;
        address_RD2 = addr2;
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: behavioural async-read RAM, stream
// collector with optional backpressure, and immediate-assertion checks.
module tb_ram_stream_reader;
    localparam int AW = 13;
    localparam int DW = 64;
    localparam int CW = 16;
    localparam int NW = 14;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [NW-1:0] word_count = '0;
    logic          busy, done, out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [AW-1:0] address_RD1, address_RD2;
    logic [DW-1:0] dataIn1, dataIn2;
    logic [CW-1:0] out_data;

    logic [DW-1:0] ram [0:8191];

    assign dataIn1 = ram[address_RD1];
    assign dataIn2 = ram[address_RD2];

    always #5 CLK = ~CLK;

    ram_stream_reader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CHUNK_WIDTH(CW),
        .COUNT_WIDTH(NW)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .address_RD1(address_RD1), .address_RD2(address_RD2),
        .dataIn1(dataIn1), .dataIn2(dataIn2), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] got_data[$];
    bit            got_last[$];
    logic [CW-1:0] exp_data[$];
    logic [AW-1:0] f_addr1[$];
    logic [AW-1:0] f_addr2[$];
    int            fetches, done_cnt, done_cyc, last_hs, first_valid;
    bit            completed, valid_seen;
    logic [15:0]   pattern;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        for (int k = 0; k < DW / CW; k++) exp_data.push_back(w[k*CW +: CW]);
    endtask

    // Called at #1 after a posedge; returns at #1 after the accepting edge.
    task automatic do_start(input logic [AW-1:0] b, input logic [NW-1:0] n);
        start = 1'b1;
        base_addr = b;
        word_count = n;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic run(input int max_cycles, input bit bp, input int inject);
        bit            ready;
        bit            prev_stall = 1'b0;
        logic [CW-1:0] prev_data = '0;
        bit            prev_last = 1'b0;
        got_data.delete(); got_last.delete(); f_addr1.delete(); f_addr2.delete();
        fetches = 0; done_cnt = 0; done_cyc = -1; last_hs = -1; first_valid = -1;
        completed = 1'b0; valid_seen = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (bp) begin
                ready   = pattern[0];
                pattern = {pattern[0], pattern[15:1]};
            end else begin
                ready = 1'b1;
            end
            out_ready = ready;
            if (c == inject) begin
                start = 1'b1; base_addr = 100; word_count = 5;
            end else begin
                start = 1'b0;
            end
            if (prev_stall) begin
                check($sformatf("stall_data_c%0d", c), out_data, prev_data);
                check($sformatf("stall_last_c%0d", c), out_last, prev_last);
            end
            if (busy && !out_valid && !done) begin
                fetches++;
                f_addr1.push_back(address_RD1);
                f_addr2.push_back(address_RD2);
            end
            if (out_valid) begin
                valid_seen = 1'b1;
                if (first_valid < 0) first_valid = c;
            end
            if (out_valid && ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                last_hs = c;
            end
            prev_stall = out_valid && !ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            @(posedge CLK); #1;
            if (done_cnt > 0 && !busy) begin
                completed = 1'b1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("run_complete", completed, 1'b1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i], i == exp_data.size() - 1);
        end
    endtask

    initial begin
        logic [63:0] w;
        bit          bad;
        for (int i = 0; i < 8192; i++) ram[i] = 64'h0;

        // Reset state
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_a1", address_RD1, 0);
        check("rst_a2", address_RD2, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Single word
        ram[5] = 64'h1122334455667788;
        ram[6] = 64'hDEADBEEFCAFEF00D;
        exp_data.delete();
        exp_data.push_back(16'h7788); exp_data.push_back(16'h5566);
        exp_data.push_back(16'h3344); exp_data.push_back(16'h1122);
        do_start(5, 1);
        check("t1_busy", busy, 1);
        check("t1_valid0", out_valid, 0);
        check("t1_a1", address_RD1, 5);
        check("t1_a2", address_RD2, 6);
        run(100, 0, -1);
        compare_stream("t1");
        check("t1_fetches", fetches, 1);
        check("t1_first_valid", first_valid, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_cyc", done_cyc, last_hs + 1);

        // Odd count
        for (int i = 0; i < 4; i++) ram[i] = 64'(i + 1);
        exp_data.delete();
        push_word(64'd1); push_word(64'd2); push_word(64'd3);
        do_start(0, 3);
        run(200, 0, -1);
        compare_stream("t2");
        check("t2_fetches", fetches, 2);
        if (f_addr1.size() == 2) begin
            check("t2_f0_a1", f_addr1[0], 0);
            check("t2_f0_a2", f_addr2[0], 1);
            check("t2_f1_a1", f_addr1[1], 2);
            check("t2_f1_a2", f_addr2[1], 3);
        end
        check("t2_done_cnt", done_cnt, 1);
        check("t2_done_cyc", done_cyc, last_hs + 1);

        // Backpressure
        ram[10] = 64'h0102030405060708;
        ram[11] = 64'h1112131415161718;
        exp_data.delete();
        push_word(ram[10]); push_word(ram[11]);
        pattern = 16'b1011_0010_1100_1001;
        do_start(10, 2);
        run(300, 1, -1);
        compare_stream("t3");
        check("t3_handshakes", 64'(got_data.size()), 8);
        check("t3_done_cnt", done_cnt, 1);

        // Zero count
        exp_data.delete();
        do_start(50, 0);
        run(20, 0, -1);
        check("t4_chunks", 64'(got_data.size()), 0);
        check("t4_valid_seen", valid_seen, 0);
        check("t4_fetches", fetches, 0);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_done_cyc", done_cyc, 0);

        // Start while busy is ignored
        ram[20]  = 64'hA1A2A3A4A5A6A7A8;
        ram[21]  = 64'hB1B2B3B4B5B6B7B8;
        ram[100] = 64'hFFFF0000FFFF0000;
        exp_data.delete();
        push_word(ram[20]); push_word(ram[21]);
        do_start(20, 2);
        run(200, 0, 3);
        compare_stream("t5");
        check("t5_fetches", fetches, 1);
        check("t5_done_cnt", done_cnt, 1);
        @(posedge CLK); #1;
        check("t5_idle_after", busy, 0);

        // Address wrap
        ram[8191] = 64'hAAAABBBBCCCCDDDD;
        ram[0]    = 64'h0123456789ABCDEF;
        exp_data.delete();
        push_word(ram[8191]); push_word(ram[0]);
        do_start(13'd8191, 2);
        check("t6_a1", address_RD1, 8191);
        check("t6_a2", address_RD2, 0);
        run(200, 0, -1);
        compare_stream("t6");
        check("t6_fetches", fetches, 1);

        // Reset during the third chunk
        for (int i = 40; i < 44; i++) ram[i] = 64'h5000_0000_0000_0000 + 64'(i);
        out_ready = 1'b1;
        do_start(40, 4);
        repeat (3) begin
            @(posedge CLK); #1;
        end
        w = ram[40];
        check("t7_valid", out_valid, 1);
        check("t7_chunk3", out_data, w[47:32]);
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        check("t7_busy", busy, 0);
        check("t7_done", done, 0);
        check("t7_valid0", out_valid, 0);
        check("t7_last", out_last, 0);
        check("t7_data", out_data, 0);
        check("t7_a1", address_RD1, 0);
        check("t7_a2", address_RD2, 0);
        bad = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
            if (done || busy) bad = 1'b1;
        end
        check("t7_no_done", bad, 0);
        exp_data.delete();
        push_word(ram[5]);
        do_start(5, 1);
        run(100, 0, -1);
        compare_stream("t7_restart");
        check("t7_restart_done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
